// File: rtl/sync_toggle_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_toggle_rx_if: toggle inputs and pulse/status outputs          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface sync_toggle_rx_if #(
  parameter int N = 4
);
  logic [N-1:0] t;
  logic         oe;
  logic         clr_ovf;
  logic [N-1:0] b;
  logic [N-1:0] pend;
  logic [N-1:0] ovf;

  modport master (output t, oe, clr_ovf, input b, pend, ovf);
  modport slave  (input t, oe, clr_ovf, output b, pend, ovf);
endinterface
`default_nettype wire

// File: rtl/sync_toggle_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_toggle_rx: multi-channel toggle-to-pulse receiver with replay |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_toggle_rx #(
  parameter int N      = 4,
  parameter int STAGES = 2,
  parameter int CW     = 3
) (
  input  logic             clk,
  input  logic             rst,
  sync_toggle_rx_if.slave  rx_if
);
  localparam int            PW         = $clog2(STAGES + 2);
  localparam logic [PW-1:0] PRIME_INIT = PW'(STAGES + 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  logic [STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]             hist_q;
  logic [PW-1:0]            prime_q;
  logic [PW-1:0]            prime_d;
  logic [CW-1:0]            cnt_q [N];
  logic [CW-1:0]            cnt_d [N];
  logic [N-1:0]             evt;
  logic [N-1:0]             take;
  logic [N-1:0]             b_q;
  logic [N-1:0]             pend_q;
  logic [N-1:0]             pend_d;
  logic [N-1:0]             ovf_q;
  logic [N-1:0]             ovf_d;

  assign prime_d = (prime_q != '0) ? prime_q - PW'(1) : prime_q;
  // Edges are ignored until the chain has flushed the reset-time level.
  assign evt     = (prime_q == '0) ? (sync_q[STAGES-1] ^ hist_q) : '0;

  always_comb begin
    take   = '0;
    pend_d = '0;
    ovf_d  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      take[i]  = rx_if.oe && ((cnt_q[i] != '0) || evt[i]);
      ovf_d[i] = ovf_q[i] && !rx_if.clr_ovf;
      if (evt[i] && !take[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else if (!evt[i] && take[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
      pend_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= '0;
      prime_q <= PRIME_INIT;
      b_q     <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], rx_if.t};
      hist_q  <= sync_q[STAGES-1];
      prime_q <= prime_d;
      b_q     <= take;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rx_if.b    = b_q;
  assign rx_if.pend = pend_q;
  assign rx_if.ovf  = ovf_q;
endmodule
`default_nettype wire
